// File: rtl/stream_mux_rr.sv
// N-channel, W-bit valid/ready stream multiplexer with a registered output stage.
// Channel choice is either a static index (sel) or fair round-robin among requesters.
module stream_mux_rr #(
  parameter int unsigned W    = 4,
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_ch
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            load_en;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;
  logic [N-1:0]    gnt;
  logic [W-1:0]    gnt_data;
  logic [SELW-1:0] rr_idx;

  assign load_en = ~out_valid_q | out_ready;

  // Grant selection. The round-robin loop walks offsets from farthest to nearest so the
  // nearest valid channel after ptr is the last (winning) assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    if (!mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end else begin
      for (int unsigned k = N; k >= 1; k--) begin
        rr_idx = SELW'((32'(ptr_q) + k) % N);
        if (in_valid[rr_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx;
        end
      end
    end
  end

  always_comb begin
    gnt      = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_vld && gnt_idx == SELW'(i)) begin
        gnt[i]   = 1'b1;
        gnt_data = in_data[i*W +: W];
      end
    end
  end

  // Ready is forced low during reset so no producer believes a beat was taken.
  assign in_ready = rst_n ? (gnt & {N{load_en}}) : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (gnt_vld) begin
        out_data_d  = gnt_data;
        out_ch_d    = gnt_idx;
        out_valid_d = 1'b1;
        if (mode) ptr_d = gnt_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus randomized traffic
// compared against a behavioural model of the grant/output rules.
module tb_stream_mux_rr;

  localparam int unsigned W    = 4;
  localparam int unsigned N    = 4;
  localparam int unsigned SELW = 3;
  localparam int unsigned DW   = N * W;

  logic            clk;
  logic            rst_n;
  logic [DW-1:0]   in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] out_ch;

  int n_total;
  int n_bad;

  // Reference model state
  int           m_ptr;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           g_cur;
  logic         load_cur;
  logic [N-1:0] exp_ready;

  stream_mux_rr #(.W(W), .N(N), .SELW(SELW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_grant(input logic md, input int s, input logic [N-1:0] v,
                                   input int p);
    if (!md) begin
      if (s < int'(N)) begin
        if (v[s]) return s;
      end
      return -1;
    end
    for (int k = 1; k <= int'(N); k++) begin
      if (v[(p + k) % int'(N)]) return (p + k) % int'(N);
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = N - 1;
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply inputs on the falling edge and work out what the model expects this cycle.
  task automatic drive(input logic [N-1:0] v, input logic [DW-1:0] d, input logic md,
                       input logic [SELW-1:0] s, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    mode      = md;
    sel       = s;
    out_ready = ordy;
    g_cur     = ref_grant(md, int'(s), v, m_ptr);
    load_cur  = !m_valid || ordy;
    exp_ready = (g_cur >= 0 && load_cur) ? N'(1 << g_cur) : '0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (load_cur) begin
      if (g_cur >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g_cur*W +: W];
        m_ch    = g_cur;
        if (mode) m_ptr = g_cur;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin
      n_bad++;
      $display("FAIL reset_init: valid=%b data=%h ch=%0d, want 0/0/0", out_valid, out_data, out_ch);
    end
    drive(4'b1111, DW'(16'h5A93), 1'b1, '0, 1'b0);
    tick();
    n_total++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_preload: out_valid=%b want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || in_ready !== '0) begin
      n_bad++;
      $display("FAIL reset_async: valid=%b data=%h ch=%0d rdy=%b, want 0/0/0/0",
               out_valid, out_data, out_ch, in_ready);
    end
    model_reset();
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive('0, '0, 1'b1, '0, 1'b1);
      tick();
      n_total++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_release: out_valid=%b want 0", out_valid);
      end
    end
  endtask

  task automatic test_static();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, DW'(16'hDCBA), 1'b0, SELW'(2), 1'b1);
      n_total++;
      if (in_ready !== 4'b0100) begin
        n_bad++;
        $display("FAIL static_ready: in_ready=%b want 0100", in_ready);
      end
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 4'hC || out_ch !== SELW'(2)) begin
        n_bad++;
        $display("FAIL static_out: valid=%b data=%h ch=%0d, want 1/c/2", out_valid, out_data,
                 out_ch);
      end
    end
    drive(4'b1111, DW'(16'hDCBA), 1'b0, SELW'(5), 1'b1);
    n_total++;
    if (in_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL static_oob_ready: in_ready=%b want 0000", in_ready);
    end
    tick();
    n_total++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL static_oob_valid: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_rr_fair();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(4'b1111, DW'($urandom), 1'b1, '0, 1'b1);
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_ch !== SELW'(seq[i]) || out_data !== m_data) begin
        n_bad++;
        $display("FAIL rr_fair[%0d]: valid=%b ch=%0d data=%h, want 1/%0d/%h", i, out_valid,
                 out_ch, out_data, seq[i], m_data);
      end
    end
  endtask

  task automatic test_rr_skip();
    int seq [7] = '{1, 3, 1, 3, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive((i < 4) ? 4'b1010 : 4'b0010, DW'($urandom), 1'b1, '0, 1'b1);
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_ch !== SELW'(seq[i])) begin
        n_bad++;
        $display("FAIL rr_skip[%0d]: valid=%b ch=%0d, want 1/%0d", i, out_valid, out_ch, seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d2;
    do_reset();
    drive(4'b1111, DW'(16'h4321), 1'b1, '0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, DW'($urandom), 1'b1, '0, 1'b0);
      n_total++;
      if (in_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL bp_ready[%0d]: in_ready=%b want 0000", i, in_ready);
      end
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 4'h1 || out_ch !== '0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ch=%0d, want 1/1/0", i, out_valid,
                 out_data, out_ch);
      end
    end
    d2 = DW'(16'h8765);
    drive(4'b1111, d2, 1'b1, '0, 1'b1);
    n_total++;
    if (in_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_release_ready: in_ready=%b want 0010", in_ready);
    end
    tick();
    n_total++;
    if (out_valid !== 1'b1 || out_ch !== SELW'(1) || out_data !== 4'h6) begin
      n_bad++;
      $display("FAIL bp_release_out: valid=%b ch=%0d data=%h, want 1/1/6", out_valid, out_ch,
               out_data);
    end
  endtask

  task automatic test_mode_switch();
    int seq [4] = '{1, 3, 3, 2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      drive(4'b0010, DW'($urandom), 1'b1, '0, 1'b1);
      else if (i < 3)  drive(4'b1111, DW'($urandom), 1'b0, SELW'(3), 1'b1);
      else             drive(4'b1111, DW'($urandom), 1'b1, '0, 1'b1);
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_ch !== SELW'(seq[i])) begin
        n_bad++;
        $display("FAIL mode_switch[%0d]: valid=%b ch=%0d, want 1/%0d", i, out_valid, out_ch,
                 seq[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom), DW'($urandom), 1'($urandom), SELW'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0));
      n_total++;
      if (in_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL rand_ready[%0d]: in_ready=%b want %b", i, in_ready, exp_ready);
      end
      tick();
      n_total++;
      if (out_valid !== m_valid || out_data !== m_data || out_ch !== SELW'(m_ch)) begin
        n_bad++;
        $display("FAIL rand_out[%0d]: valid=%b data=%h ch=%0d, want %b/%h/%0d", i, out_valid,
                 out_data, out_ch, m_valid, m_data, m_ch);
      end
    end
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    g_cur     = -1;
    load_cur  = 1'b0;
    exp_ready = '0;
    model_reset();
    #12;
    test_reset();
    test_static();
    test_rr_fair();
    test_rr_skip();
    test_backpressure();
    test_mode_switch();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit streaming multiplexer; successor to the combinational 2:1 4-bit select mux.
- Each input channel has a valid/ready handshake. The output is registered.
- Two selection modes:
  - static: the `sel` port picks the channel.
  - round-robin: fair arbitration among requesting channels.
- Used wherever several producers share one datapath consumer.

Parameters:
- W, 4, data width per channel (≥1)
- N, 4, number of input channels (2..16)
- SELW, 2, width of channel index; N ≤ 2^SELW required

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N*W  channel i data at bits [i*W+W-1 : i*W]
- in_valid  input  N  channel i has a beat
- in_ready  output  N  channel i beat accepted this cycle when in_valid[i] & in_ready[i]
- mode  input  1  0 = static select, 1 = round-robin
- sel  input  SELW  channel index used in static mode
- out_data  output  W  registered output beat
- out_valid  output  1  out_data holds a beat
- out_ready  input  1  consumer accepts the beat when out_valid & out_ready
- out_ch  output  SELW  index of the channel that supplied out_data

Behaviour:
- Single clock `clk`. Asynchronous active-low reset `rst_n` clears all state immediately, independent of clk.
- Reset values:
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer ptr = N-1, so channel 0 has first priority.
  - in_ready = 0 while rst_n = 0.
- load_en = ~out_valid | out_ready. The output register can take a new beat when it is empty or is being drained this cycle. This gives full throughput: 1 beat/cycle.
- Grant is combinational, at most one-hot:
  - Static mode (mode = 0): grant channel sel if sel < N and in_valid[sel]. If sel ≥ N, no grant; all in_ready stay 0.
  - Round-robin mode (mode = 1): search channels ptr+1, ptr+2, … modulo N (wraps N-1 → 0). Grant the first channel with in_valid set. If no channel is valid, no grant.
- in_ready[i] = grant[i] & load_en. No other channel sees ready.
- On a clock edge with a transfer (granted channel g, load_en = 1):
  - out_data ← channel g data.
  - out_ch ← g.
  - out_valid ← 1.
  - If mode = 1, ptr ← g.
- On an edge with load_en = 1 and no grant: out_valid ← 0. out_data and out_ch hold their last values.
- On an edge with out_valid = 1 and out_ready = 0 (stall): out_data, out_ch and out_valid hold. All in_ready are 0.
- Latency: a beat accepted at edge k is visible on out_data after edge k.
- ptr changes only on a round-robin transfer. It holds in static mode, so round-robin resumes fairly after a mode change.
- mode and sel may change on any cycle. They affect only that cycle's grant; a beat already in the output register is unaffected.
- Simultaneous drain and load in the same cycle is legal. The new beat replaces the old with no bubble.
- If rst_n is asserted while out_valid = 1, the pending beat is discarded; no beat is emitted after reset release.
- in_valid is not required to be held by producers. The block never accepts a beat whose in_valid is 0.

Test Plan:
- Reset: rst_n = 0 mid-stream with out_valid = 1 → out_valid, out_data and out_ch drop to 0 immediately, before any clk edge. After release with no inputs valid, out_valid stays 0.
- Static select: N = 4, W = 4, mode = 0, sel = 2, all in_valid = 1, data = {ch3 = 0xD, ch2 = 0xC, ch1 = 0xB, ch0 = 0xA}, out_ready = 1 → in_ready = 0100 every cycle. out_data = 0xC, out_ch = 2 from the cycle after the first edge. With sel = 5 (≥N): in_ready = 0000 and out_valid falls to 0.
- Round-robin fairness: mode = 1, all four valid, out_ready = 1 → out_ch sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Round-robin skip and wrap: only ch1 and ch3 valid, starting after reset → out_ch 1,3,1,3. Then drop ch3 → out_ch 1,1,1.
- Backpressure: out_ready = 0 for 3 cycles while out_valid = 1 → out_data and out_ch stable and in_ready = 0000. On out_ready = 1, the next beat loads in the same cycle the held one drains.
- Mode switch: in round-robin, grant ch1. Switch to mode = 0, sel = 3 for 2 beats (out_ch 3,3). Return to mode = 1 with all valid → next out_ch = 2, since ptr held at 1.
